// File: rtl/edit_mem_read_count_tracker_pkg.sv
// Shared widths, operation encodings and the set-FIFO entry layout for the
// edit-memory read-count tracker.
package edit_mem_read_count_tracker_pkg;

  localparam int EM_BUF_PTR_NBITS       = 6;
  localparam int PORT_ID_NBITS          = 3;
  localparam int READ_COUNT_NBITS       = 4;
  localparam int EM_RC_FIFO_DEPTH_NBITS = 4;

  typedef logic [EM_BUF_PTR_NBITS-1:0] buf_ptr_t;
  typedef logic [READ_COUNT_NBITS-1:0] read_count_t;

  localparam read_count_t RC_ONE = read_count_t'(1);

  typedef enum logic {
    RR_REL = 1'b0,
    RR_SET = 1'b1
  } rr_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_SET  = 2'd1,
    OP_REL  = 2'd2
  } op_e;

  typedef struct packed {
    logic [PORT_ID_NBITS-1:0] port_id;
    buf_ptr_t                 ptr;
    read_count_t              count;
  } set_entry_t;

endpackage

// File: rtl/edit_mem_read_count_tracker_if.sv
// Bus between the read-count producers/consumers and the tracker.
interface edit_mem_read_count_tracker_if;
  import edit_mem_read_count_tracker_pkg::*;

  logic                     read_count_valid;
  logic [PORT_ID_NBITS-1:0] read_count_port_id;
  buf_ptr_t                 read_count_buf_ptr;
  read_count_t              read_count;
  logic                     buf_rel_valid;
  buf_ptr_t                 buf_rel_ptr;
  logic                     buf_rel_ready;
  logic                     free_buf_valid;
  buf_ptr_t                 free_buf_ptr;
  logic                     free_buf_ready;
  logic                     rc_overflow_err;
  logic                     rel_underflow_err;

  modport master (
    output read_count_valid, read_count_port_id, read_count_buf_ptr, read_count,
    output buf_rel_valid, buf_rel_ptr, free_buf_ready,
    input  buf_rel_ready, free_buf_valid, free_buf_ptr,
    input  rc_overflow_err, rel_underflow_err
  );

  modport slave (
    input  read_count_valid, read_count_port_id, read_count_buf_ptr, read_count,
    input  buf_rel_valid, buf_rel_ptr, free_buf_ready,
    output buf_rel_ready, free_buf_valid, free_buf_ptr,
    output rc_overflow_err, rel_underflow_err
  );
endinterface

// File: rtl/edit_mem_read_count_tracker_prims.sv
// Storage primitives for the tracker: a first-word-fall-through FIFO and a
// 1-read/1-write RAM with one cycle of read latency.
module sfifo2f_fo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // NOTE: storage arrays are not reset; only the pointers and count are, which
  // keeps the array mappable onto RAM cells and makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout = mem[rptr];
endmodule

module ram_1r1w_ultra #(
  parameter int AW = 6,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);
  logic [DW-1:0] mem [2**AW];

  // A same-address read and write return the old data; the caller forwards.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/edit_mem_read_count_tracker.sv
// Read-count tracker: queues count sets, decrements on egress releases and
// returns buffers to the free pool when their count reaches zero.
module edit_mem_read_count_tracker
  import edit_mem_read_count_tracker_pkg::*;
(
  input logic                           clk,
  input logic                           rst,
  edit_mem_read_count_tracker_if.slave  bus
);

  localparam int FCNT_NBITS = EM_RC_FIFO_DEPTH_NBITS + 1;
  localparam logic [FCNT_NBITS-1:0] SET_FULL_COUNT = FCNT_NBITS'(1 << EM_RC_FIFO_DEPTH_NBITS);
  localparam logic [FCNT_NBITS-1:0] STALL_COUNT    = FCNT_NBITS'((1 << EM_RC_FIFO_DEPTH_NBITS) - 1);

  set_entry_t             set_din;
  set_entry_t             set_head;
  logic [FCNT_NBITS-1:0]  set_count;
  logic                   set_empty;
  logic                   set_full;
  logic                   set_push;

  buf_ptr_t               free_head;
  logic [FCNT_NBITS-1:0]  free_count;
  logic                   free_empty;
  logic                   free_pop;

  rr_e                    rr_q;
  logic                   stall;
  logic                   both_pend;
  logic                   rel_ready;
  logic                   grant_rel;
  logic                   grant_set;
  buf_ptr_t               s0_ptr;

  op_e                    s1_op;
  buf_ptr_t               s1_ptr;
  read_count_t            s1_count;
  read_count_t            ram_rdata;
  read_count_t            cur;
  logic                   s1_wr;
  read_count_t            s1_wdata;
  logic                   s1_push;
  logic                   s1_underflow;

  logic                   fwd_valid;
  buf_ptr_t               fwd_ptr;
  read_count_t            fwd_data;
  logic                   overflow_q;
  logic                   underflow_q;

  // Set path: entries are dropped, not back-pressured, when the FIFO is full.
  assign set_din   = '{port_id: bus.read_count_port_id,
                       ptr:     bus.read_count_buf_ptr,
                       count:   bus.read_count};
  assign set_empty = (set_count == '0);
  assign set_full  = (set_count == SET_FULL_COUNT);
  assign set_push  = bus.read_count_valid & ~set_full;

  sfifo2f_fo #(.W($bits(set_entry_t)), .AW(EM_RC_FIFO_DEPTH_NBITS)) u_set_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (set_push),
    .din   (set_din),
    .pop   (grant_set),
    .dout  (set_head),
    .count (set_count)
  );

  // Stall counts the push S1 is about to make so the free FIFO never overfills.
  assign stall     = (free_count + FCNT_NBITS'(s1_push)) >= STALL_COUNT;
  assign both_pend = ~set_empty & bus.buf_rel_valid;
  assign rel_ready = ~stall & (set_empty | (rr_q == RR_REL));
  assign grant_rel = bus.buf_rel_valid & rel_ready;
  assign grant_set = ~stall & ~set_empty & ~grant_rel;
  assign s0_ptr    = grant_rel ? bus.buf_rel_ptr : set_head.ptr;

  ram_1r1w_ultra #(.AW(EM_BUF_PTR_NBITS), .DW(READ_COUNT_NBITS)) u_count_ram (
    .clk   (clk),
    .raddr (s0_ptr),
    .rdata (ram_rdata),
    .wen   (s1_wr),
    .waddr (s1_ptr),
    .wdata (s1_wdata)
  );

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    cur          = (fwd_valid && (fwd_ptr == s1_ptr)) ? fwd_data : ram_rdata;
    s1_wr        = 1'b0;
    s1_wdata     = '0;
    s1_push      = 1'b0;
    s1_underflow = 1'b0;
    unique case (s1_op)
      OP_SET: begin
        s1_wr    = 1'b1;
        s1_wdata = s1_count;
        s1_push  = (s1_count == '0);
      end
      OP_REL: begin
        if (cur == '0) begin
          s1_underflow = 1'b1;
        end else begin
          s1_wr    = 1'b1;
          s1_wdata = cur - RC_ONE;
          s1_push  = (cur == RC_ONE);
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= RR_REL;
      s1_op       <= OP_NONE;
      s1_ptr      <= '0;
      s1_count    <= '0;
      fwd_valid   <= 1'b0;
      fwd_ptr     <= '0;
      fwd_data    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (both_pend && !stall) rr_q <= (rr_q == RR_REL) ? RR_SET : RR_REL;
      s1_op       <= grant_rel ? OP_REL : (grant_set ? OP_SET : OP_NONE);
      s1_ptr      <= s0_ptr;
      s1_count    <= set_head.count;
      fwd_valid   <= s1_wr;
      fwd_ptr     <= s1_ptr;
      fwd_data    <= s1_wdata;
      overflow_q  <= bus.read_count_valid & set_full;
      underflow_q <= s1_underflow;
    end
  end

  assign free_empty = (free_count == '0);
  assign free_pop   = ~free_empty & bus.free_buf_ready;

  sfifo2f_fo #(.W(EM_BUF_PTR_NBITS), .AW(EM_RC_FIFO_DEPTH_NBITS)) u_free_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_push),
    .din   (s1_ptr),
    .pop   (free_pop),
    .dout  (free_head),
    .count (free_count)
  );

  assign bus.buf_rel_ready     = rel_ready;
  assign bus.free_buf_valid    = ~free_empty;
  assign bus.free_buf_ptr      = free_head;
  assign bus.rc_overflow_err   = overflow_q;
  assign bus.rel_underflow_err = underflow_q;

endmodule

// File: tb/tb_edit_mem_read_count_tracker.sv
// Directed bench for the read-count tracker with a free-pointer scoreboard.
module tb_edit_mem_read_count_tracker;
  import edit_mem_read_count_tracker_pkg::*;

  localparam int NO_EXP   = -2;
  localparam int UNTIMED  = -1;

  typedef struct {
    int ptr;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   uf_cnt = 0;
  int   uf_cyc = 0;
  int   oc_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  edit_mem_read_count_tracker_if bus ();

  edit_mem_read_count_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: compares every delivered free pointer against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.free_buf_valid && bus.free_buf_ready) begin
        if (exp_q.size() == 0) begin
          check("free_unexpected", int'(bus.free_buf_ptr), -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("free_ptr", int'(bus.free_buf_ptr), mon_e.ptr);
          if (mon_e.cyc >= 0) check("free_cycle", cyc, mon_e.cyc);
        end
      end
      if (bus.rel_underflow_err) begin
        uf_cnt++;
        uf_cyc = cyc;
      end
      if (bus.rc_overflow_err) oc_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_free(input int ptr, input int dly);
    exp_t e;
    if (dly != NO_EXP) begin
      e.ptr = ptr;
      e.cyc = (dly == UNTIMED) ? UNTIMED : cyc + dly;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_set(input int ptr, input int cnt, input int dly);
    expect_free(ptr, dly);
    bus.read_count_valid   = 1'b1;
    bus.read_count_port_id = PORT_ID_NBITS'(ptr);
    bus.read_count_buf_ptr = buf_ptr_t'(ptr);
    bus.read_count         = read_count_t'(cnt);
    tick();
    bus.read_count_valid   = 1'b0;
  endtask

  task automatic drive_rel(input int ptr, input int dly);
    expect_free(ptr, dly);
    bus.buf_rel_valid = 1'b1;
    bus.buf_rel_ptr   = buf_ptr_t'(ptr);
    tick();
    bus.buf_rel_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int exp_rdy[6] = '{1, 1, 0, 1, 0, 1};
    int uf0;
    int oc0;
    int t3;

    bus.read_count_valid   = 1'b0;
    bus.read_count_port_id = '0;
    bus.read_count_buf_ptr = '0;
    bus.read_count         = '0;
    bus.buf_rel_valid      = 1'b0;
    bus.buf_rel_ptr        = '0;
    bus.free_buf_ready     = 1'b1;

    ticks(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_free_valid", int'(bus.free_buf_valid), 0);
    check("rst_rel_ready", int'(bus.buf_rel_ready), 1);
    check("rst_overflow", int'(bus.rc_overflow_err), 0);
    check("rst_underflow", int'(bus.rel_underflow_err), 0);
    tick();

    // Count 3 then three spaced releases: one free, two cycles after the last.
    drive_set(5, 3, NO_EXP);
    ticks(3);
    drive_rel(5, NO_EXP);
    ticks(3);
    drive_rel(5, NO_EXP);
    ticks(3);
    drive_rel(5, 2);
    ticks(6);
    check("rel3_drained", exp_q.size(), 0);

    // Count 0 set frees immediately.
    uf0 = uf_cnt;
    drive_set(9, 0, 3);
    ticks(6);
    check("set0_drained", exp_q.size(), 0);
    check("set0_no_underflow", uf_cnt - uf0, 0);

    // Back-to-back releases use the forwarded count; a third underflows.
    drive_set(7, 2, NO_EXP);
    ticks(3);
    drive_rel(7, NO_EXP);
    drive_rel(7, 2);
    ticks(3);
    check("fwd_underflow_none", uf_cnt - uf0, 0);
    t3 = cyc;
    drive_rel(7, NO_EXP);
    ticks(4);
    check("fwd_drained", exp_q.size(), 0);
    check("underflow_count", uf_cnt - uf0, 1);
    check("underflow_cycle", uf_cyc, t3 + 2);

    // Continuous sets and releases: release grants in cycles 0,1,3,5 only.
    drive_set(20, 5, NO_EXP);
    ticks(3);
    for (int i = 0; i < 6; i++) begin
      bus.read_count_valid   = 1'b1;
      bus.read_count_buf_ptr = buf_ptr_t'(30 + i);
      bus.read_count         = read_count_t'(2);
      bus.buf_rel_valid      = 1'b1;
      bus.buf_rel_ptr        = buf_ptr_t'(20);
      @(negedge clk);
      check("arb_rel_ready", int'(bus.buf_rel_ready), exp_rdy[i]);
      tick();
    end
    bus.read_count_valid = 1'b0;
    bus.buf_rel_valid    = 1'b0;
    ticks(10);
    drive_rel(20, 2);
    ticks(5);
    check("arb_drained", exp_q.size(), 0);

    // Free FIFO back-pressure: 20 frees queue up, releases stall, order kept.
    bus.free_buf_ready = 1'b0;
    for (int i = 0; i < 20; i++) drive_set(40 + i, 0, UNTIMED);
    ticks(10);
    @(negedge clk);
    check("bp_rel_ready", int'(bus.buf_rel_ready), 0);
    check("bp_free_valid", int'(bus.free_buf_valid), 1);
    check("bp_free_ptr", int'(bus.free_buf_ptr), 40);
    ticks(3);
    @(negedge clk);
    check("bp_free_ptr_held", int'(bus.free_buf_ptr), 40);
    check("bp_no_overflow", oc_cnt, 0);
    tick();
    bus.free_buf_ready = 1'b1;
    wait_drain("bp_drained", 200);
    ticks(6);
    check("bp_no_extra", exp_q.size(), 0);

    // Overflow while stalled, then reset in the middle of it all.
    bus.free_buf_ready = 1'b0;
    for (int i = 0; i < 15; i++) drive_set(i, 0, NO_EXP);
    ticks(10);
    @(negedge clk);
    check("ovf_stalled", int'(bus.buf_rel_ready), 0);
    tick();
    oc0 = oc_cnt;
    for (int i = 0; i < 17; i++) drive_set(15 + i, 0, NO_EXP);
    ticks(3);
    check("ovf_pulses", oc_cnt - oc0, 1);
    rst = 1'b1;
    ticks(2);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_free_valid", int'(bus.free_buf_valid), 0);
    check("mid_rst_rel_ready", int'(bus.buf_rel_ready), 1);
    check("mid_rst_overflow", int'(bus.rc_overflow_err), 0);
    tick();
    bus.free_buf_ready = 1'b1;
    drive_set(3, 0, 3);
    wait_drain("post_rst_drained", 20);
    ticks(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/edit_mem_read_count_tracker.md
# edit_mem_read_count_tracker

Consumer end of the edit-memory read-count interface. Takes the per-buffer read counts published by the linked-list block, decrements each count as egress ports release buffers, and returns a buffer pointer to the free pool when its count reaches zero. Sits between the edit-memory linked list, the egress readers and the buffer free-list manager.

## Interface
- BPTR_NBITS, `EM_BUF_PTR_NBITS: buffer pointer width; count RAM depth is 2^BPTR_NBITS.
- ID_NBITS, `PORT_ID_NBITS: port id width.
- RC_NBITS, `READ_COUNT_NBITS: read count width.
- FIFO_DEPTH_NBITS, 4: log2 depth of the set FIFO and the free FIFO.

Ports:
- clk  in  1  single clock.
- `RESET_SIG  in  1  asynchronous, active-high reset.
- read_count_valid  in  1  set request; there is no backpressure.
- read_count_port_id  in  ID_NBITS  source port; carried for debug only.
- read_count_buf_ptr  in  BPTR_NBITS  buffer whose count is set.
- read_count  in  RC_NBITS  number of reads pending on the buffer.
- buf_rel_valid  in  1  one read of a buffer completed.
- buf_rel_ptr  in  BPTR_NBITS  released buffer.
- buf_rel_ready  out  1  release accepted when valid&ready.
- free_buf_valid  out  1  free pointer available.
- free_buf_ptr  out  BPTR_NBITS  pointer returned to the free pool.
- free_buf_ready  in  1  pool accepts the pointer when valid&ready.
- rc_overflow_err  out  1  one-cycle pulse: a set was dropped because the set FIFO was full.
- rel_underflow_err  out  1  one-cycle pulse: a release hit a count of 0.

## Operation
- Set path:
  - read_count_valid pushes {port_id, ptr, count} into the set FIFO.
  - If the FIFO is full, the entry is dropped and rc_overflow_err pulses.
- Arbiter (S0): grants at most one op per cycle.
  - Candidates are a set (set FIFO non-empty) and a release (buf_rel_valid).
  - When both are pending, a round-robin bit alternates between them and toggles after each grant made while both were pending.
  - buf_rel_ready = ~stall & (set_fifo_empty | rr_bit==REL). It does not depend on buf_rel_valid.
  - The granted op's ptr drives the count RAM raddr combinationally.
- S1, compute and write:
  - cur = RAM dout, except when the previous op's write is to the same ptr (fwd_valid & fwd_ptr==ptr); then cur = fwd_data.
  - Set: new = read_count. If read_count==0, push ptr to the free FIFO.
  - Release with cur==0: no write, no free push, rel_underflow_err pulses.
  - Release with cur==1: write 0 and push ptr to the free FIFO.
  - Release otherwise: write cur-1.
  - Subtraction is RC_NBITS wide and never wraps.
  - Register fwd_ptr, fwd_data and fwd_valid from every S1 write.
- Stall:
  - stall = (free_fifo_count + S1_pending_push) >= 2^FIFO_DEPTH_NBITS - 1.
  - While stalled there is no S0 grant for either op type, and set FIFO entries wait.
- Producers guarantee that a buffer's set is accepted at least 3 cycles before its first release. A release arriving ahead of its set is undefined behaviour.
- Count RAM contents are not reset.

## Timing
- Reset values:
  - free_buf_valid=0, rc_overflow_err=0, rel_underflow_err=0.
  - buf_rel_ready=1 (FIFOs empty, rr_bit=REL).
  - rr_bit=REL, fwd_valid=0.
  - Both FIFOs are emptied.
  - Reset mid-operation discards in-flight ops and queued frees.
- Release accepted at cycle T: S0=T, RAM write at the end of T+1, free_buf_valid at T+2.
- Set presented at cycle T: FIFO write at T, earliest S0 at T+1, count written at the end of T+2, free at T+3 (count==0 case only).
- Back-to-back ops to the same ptr read the forwarded value; this covers up to one release per cycle sustained.
- Error pulses are registered and are asserted in the cycle after S1.
- free_buf_ptr is held stable while free_buf_valid & ~free_buf_ready.

## Structure
- Width macros come from defines.vh. Add one new define there: EM_RC_FIFO_DEPTH_NBITS.
- Sub-modules:
  - sfifo2f_fo ×2: the set FIFO and the free FIFO.
  - ram_1r1w_ultra: 2^BPTR_NBITS × RC_NBITS count RAM, 1-cycle read latency.
- All remaining logic (arbiter, S1 compute, forwarding, stall) is in this module, with no further hierarchy.

## Test plan
- Set ptr 5 to count 3, then 3 releases of ptr 5 spaced 4 cycles apart → exactly one free_buf_ptr=5, 2 cycles after the third release.
- Set ptr 9 to count 0 → free_buf_ptr=9 three cycles later; no RAM-dependent error.
- Set ptr 7 to count 2, then releases of ptr 7 on two consecutive cycles → forwarding yields one free of 7, no underflow. A third release of 7 → rel_underflow_err pulse and no free.
- Sets every cycle plus continuous buf_rel_valid → grants alternate set/release. buf_rel_ready toggles 1,0,1,0; no starvation.
- free_buf_ready=0 with 20 counts driven to zero → free FIFO fills, buf_rel_ready=0, no pointer lost. Releasing free_buf_ready → all 20 pointers delivered in order.
- 17 read_count_valid pulses while stalled → rc_overflow_err pulses once. Assert reset mid-stream → free_buf_valid=0 and buf_rel_ready=1 on the first cycle after reset.
